// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin arbitration and pop-scheduling blocks.
package rr_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } sched_state_e;

  // Selector width for a given queue count; never narrower than one bit.
  function automatic int unsigned sel_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with an asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + One;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fifo_pop_scheduler.sv
// Turns arbiter grants into single-cycle FIFO pops, registers the popped word for a
// valid/ready downstream and pauses popping with hysteresis on downstream occupancy.
module fifo_pop_scheduler
  import rr_pkg::*;
#(
  parameter int unsigned QUEUE_QUANTITY = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned BUF_WIDTH      = 3,
  parameter int unsigned HIGH_THRESHOLD = 6,
  parameter int unsigned LOW_THRESHOLD  = 2,
  parameter int unsigned CNT_BITS       = 8,
  localparam int unsigned SEL_BITS      = sel_bits(QUEUE_QUANTITY)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_enb,
  input  logic [SEL_BITS-1:0]                i_selector,
  input  logic                               i_selector_enb,
  input  logic [QUEUE_QUANTITY-1:0]          i_buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] i_data_in,
  input  logic [BUF_WIDTH-1:0]               i_down_count,
  input  logic                               i_ready_in,
  output logic [QUEUE_QUANTITY-1:0]          o_pop,
  output logic [DATA_BITS-1:0]               o_data_out,
  output logic                               o_valid_out,
  output logic [1:0]                         o_state,
  output logic [QUEUE_QUANTITY*CNT_BITS-1:0] o_pop_counts
);

  sched_state_e                  r_state, w_state_next;
  logic                          r_valid;
  logic [DATA_BITS-1:0]          r_data;
  logic                          w_slot_free;
  logic                          w_sel_ok;
  logic [QUEUE_QUANTITY-1:0]     w_pop;
  logic [DATA_BITS-1:0]          w_word;

  assign w_slot_free = !r_valid || i_ready_in;
  assign w_sel_ok    = 32'(i_selector) < QUEUE_QUANTITY;

  always_comb begin
    w_pop = '0;
    if ((r_state == StRun) && i_selector_enb && w_sel_ok && w_slot_free) begin
      if (!i_buf_empty[i_selector]) begin
        w_pop[i_selector] = 1'b1;
      end
    end
  end

  // Mux driven by the one-hot pop so an out-of-range selector never indexes data_in.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < int'(QUEUE_QUANTITY); i++) begin
      if (w_pop[i]) begin
        w_word = i_data_in[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (|w_pop) begin
      r_valid <= 1'b1;
      r_data  <= w_word;
    end else if (i_ready_in) begin
      r_valid <= 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!i_enb) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  w_state_next = StRun;
        StRun:   if (32'(i_down_count) >= HIGH_THRESHOLD) w_state_next = StPause;
        StPause: if (32'(i_down_count) <= LOW_THRESHOLD)  w_state_next = StRun;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  for (genvar g = 0; g < int'(QUEUE_QUANTITY); g++) begin : g_cnt
    sat_counter #(
      .WIDTH (CNT_BITS)
    ) u_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (w_pop[g]),
      .o_count (o_pop_counts[g*CNT_BITS +: CNT_BITS])
    );
  end

  assign o_pop       = w_pop;
  assign o_data_out  = r_data;
  assign o_valid_out = r_valid;
  assign o_state     = r_state;

endmodule

// File: tb/tb_fifo_pop_scheduler.sv
// Directed plus random bench for fifo_pop_scheduler against a cycle-level behavioural model.
module tb_fifo_pop_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [1:0]  sel;
  logic        sel_enb;
  logic [3:0]  empty;
  logic [31:0] data_in;
  logic [2:0]  down;
  logic        ready;
  logic [3:0]  pop;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  state;
  logic [11:0] counts;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Model: state 0 idle / 1 run / 2 pause, output slot, saturating counts (max 7).
  int         m_st;
  bit         m_v;
  logic [7:0] m_d;
  int         m_c[4];

  fifo_pop_scheduler #(
    .QUEUE_QUANTITY (4),
    .DATA_BITS      (8),
    .BUF_WIDTH      (3),
    .HIGH_THRESHOLD (6),
    .LOW_THRESHOLD  (2),
    .CNT_BITS       (3)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enb          (enb),
    .i_selector     (sel),
    .i_selector_enb (sel_enb),
    .i_buf_empty    (empty),
    .i_data_in      (data_in),
    .i_down_count   (down),
    .i_ready_in     (ready),
    .o_pop          (pop),
    .o_data_out     (data_out),
    .o_valid_out    (valid_out),
    .o_state        (state),
    .o_pop_counts   (counts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_st = 0;
    m_v  = 1'b0;
    m_d  = 8'h00;
    for (int i = 0; i < 4; i++) m_c[i] = 0;
  endtask

  function automatic logic [3:0] mpop();
    if (rst && m_st == 1 && sel_enb && int'(sel) < 4 && !empty[sel] && (!m_v || ready))
      return 4'b0001 << sel;
    return 4'b0000;
  endfunction

  task automatic check_all();
    logic [11:0] ec;
    ec = {3'(m_c[3]), 3'(m_c[2]), 3'(m_c[1]), 3'(m_c[0])};
    chk("state", 32'(state), 32'(m_st));
    chk("pop", 32'(pop), 32'(mpop()));
    chk("valid_out", 32'(valid_out), 32'(m_v));
    chk("data_out", 32'(data_out), 32'(m_d));
    chk("pop_counts", 32'(counts), 32'(ec));
  endtask

  // Inputs are driven at the falling edge; check, take one rising edge, advance model.
  task automatic step();
    logic [3:0] p;
    #1;
    if (!rst) mreset();
    p = mpop();
    check_all();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) if (p[i] && m_c[i] < 7) m_c[i]++;
      if (p != 4'b0000) begin
        m_d = data_in[8*int'(sel) +: 8];
        m_v = 1'b1;
      end else if (ready) begin
        m_v = 1'b0;
      end
      if (!enb) m_st = 0;
      else if (m_st == 0) m_st = 1;
      else if (m_st == 1 && down >= 3'd6) m_st = 2;
      else if (m_st == 2 && down <= 3'd2) m_st = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; enb = 1'b1; sel = 2'd0; sel_enb = 1'b1; empty = 4'b0000;
    data_in = 32'hA3A2A1A0; down = 3'd0; ready = 1'b1;
    mreset();
    @(negedge clk);
    step();
    step();
    rst = 1'b1;
    step();

    // Streaming one word per cycle across all queues.
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
    end
    sel_enb = 1'b0;
    step();

    // Grant to an empty queue.
    sel_enb = 1'b1; sel = 2'd2; empty = 4'b0100;
    step();
    step();
    empty = 4'b0000;

    // Backpressure: load a word, stall three cycles, then accept and pop together.
    sel = 2'd1; data_in = 32'h11223344;
    step();
    ready = 1'b0; sel = 2'd3;
    repeat (3) step();
    ready = 1'b1;
    step();

    // Hysteresis ramp up and down.
    for (int i = 0; i < 8; i++) begin
      down = 3'(i); sel = 2'(i);
      step();
    end
    for (int i = 7; i >= 0; i--) begin
      down = 3'(i); sel = 2'(i);
      step();
    end

    // Saturate queue 1.
    sel = 2'd1;
    repeat (10) step();

    // Random traffic with one mid-cycle asynchronous reset.
    for (int k = 0; k < 400; k++) begin
      enb     = ($urandom_range(15) != 0);
      sel     = 2'($urandom_range(3));
      sel_enb = ($urandom_range(3) != 0);
      empty   = 4'($urandom);
      data_in = $urandom;
      down    = 3'($urandom);
      ready   = ($urandom_range(3) != 0);
      if (k == 200) begin
        #2 rst = 1'b0;
        #1 mreset();
        check_all();
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
